// File: rtl/diff_freq_pkg.sv
// Shared definitions for the multi-channel differential-frequency serial output block:
// control-byte layout, mode encodings, channel states and the packet length helper.
package diff_freq_pkg;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_W   = 2;
  localparam int CTRL_IDLE_BIT = 2;
  localparam int CTRL_CH_LSB   = 4;
  localparam int CTRL_CH_W     = 4;

  typedef enum logic [1:0] {
    MODE_NOP     = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_REPEAT  = 2'b10,
    MODE_STOP    = 2'b11
  } mode_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Output pattern bytes, frequency pattern bytes, then one control byte.
  function automatic int calc_pack_num(input int data_bit);
    return (data_bit / 8) * 2 + 1;
  endfunction

endpackage

// File: rtl/dfso_channel.sv
// One serialiser engine: shadow registers for the next pass, a shift register for the
// current pass, and a down-counting bit period timer selected by the frequency pattern.
module dfso_channel
  import diff_freq_pkg::*;
#(
  parameter int DATA_BIT = 32,
  parameter int FAST_DIV = 10,
  parameter int SLOW_DIV = 20,
  parameter int DIV_BIT  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                disp_en,
  input  mode_e               disp_mode,
  input  logic                disp_idle,
  input  logic [DATA_BIT-1:0] disp_pattern,
  input  logic [DATA_BIT-1:0] disp_freq,
  output logic                serial_out,
  output logic                bit_tick,
  output logic                done_tick,
  output logic                busy
);

  localparam int                 BCNT_W    = $clog2(DATA_BIT);
  localparam logic [DIV_BIT-1:0] FAST_LOAD = DIV_BIT'(FAST_DIV - 1);
  localparam logic [DIV_BIT-1:0] SLOW_LOAD = DIV_BIT'(SLOW_DIV - 1);
  localparam logic [DIV_BIT-1:0] DIV_ONE   = DIV_BIT'(1);
  localparam logic [BCNT_W-1:0]  LAST_BIT  = BCNT_W'(DATA_BIT - 1);

  ch_state_e           state;
  logic [DATA_BIT-1:0] shadow_pat;
  logic [DATA_BIT-1:0] shadow_freq;
  logic [DATA_BIT-1:0] shift_pat;
  logic [DATA_BIT-1:0] shift_freq;
  logic                shadow_rep;
  logic                pending;
  logic                idle_lvl;
  logic [DIV_BIT-1:0]  div_cnt;
  logic [BCNT_W-1:0]   bit_cnt;

  logic                start_req;
  logic                stop_req;
  logic [DATA_BIT-1:0] eff_pat;
  logic [DATA_BIT-1:0] eff_freq;
  logic                eff_idle;
  logic                eff_rep;
  logic                eff_pend;

  // A dispatch arriving in the same cycle as a pass end must win over the stored shadow.
  always_comb begin
    start_req = disp_en && ((disp_mode == MODE_ONESHOT) || (disp_mode == MODE_REPEAT));
    stop_req  = disp_en && (disp_mode == MODE_STOP);
    eff_pat   = disp_en ? disp_pattern : shadow_pat;
    eff_freq  = disp_en ? disp_freq : shadow_freq;
    eff_idle  = disp_en ? disp_idle : idle_lvl;
    eff_rep   = start_req ? (disp_mode == MODE_REPEAT) : shadow_rep;
    eff_pend  = start_req || pending;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CH_IDLE;
      shadow_pat  <= '0;
      shadow_freq <= '0;
      shift_pat   <= '0;
      shift_freq  <= '0;
      shadow_rep  <= 1'b0;
      pending     <= 1'b0;
      idle_lvl    <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      serial_out  <= 1'b0;
      bit_tick    <= 1'b0;
      done_tick   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bit_tick  <= 1'b0;
      done_tick <= 1'b0;
      if (disp_en) begin
        shadow_pat  <= disp_pattern;
        shadow_freq <= disp_freq;
        idle_lvl    <= disp_idle;
      end
      if (start_req) begin
        shadow_rep <= (disp_mode == MODE_REPEAT);
      end
      case (state)
        CH_IDLE: begin
          if (start_req) begin
            state      <= CH_RUN;
            busy       <= 1'b1;
            pending    <= 1'b0;
            shift_pat  <= disp_pattern;
            shift_freq <= disp_freq;
            serial_out <= disp_pattern[0];
            div_cnt    <= disp_freq[0] ? FAST_LOAD : SLOW_LOAD;
            bit_cnt    <= '0;
          end else begin
            serial_out <= eff_idle;
          end
        end
        CH_RUN: begin
          if (stop_req) begin
            state      <= CH_IDLE;
            busy       <= 1'b0;
            pending    <= 1'b0;
            serial_out <= disp_idle;
          end else if (div_cnt != '0) begin
            // Ticks are registered one cycle early so they land on the bit's final cycle.
            div_cnt   <= div_cnt - 1'b1;
            bit_tick  <= (div_cnt == DIV_ONE);
            done_tick <= (div_cnt == DIV_ONE) && (bit_cnt == LAST_BIT);
            if (start_req) begin
              pending <= 1'b1;
            end
          end else if (bit_cnt != LAST_BIT) begin
            shift_pat  <= shift_pat >> 1;
            shift_freq <= shift_freq >> 1;
            serial_out <= shift_pat[1];
            div_cnt    <= shift_freq[1] ? FAST_LOAD : SLOW_LOAD;
            bit_cnt    <= bit_cnt + 1'b1;
            if (start_req) begin
              pending <= 1'b1;
            end
          end else if (eff_rep || eff_pend) begin
            pending    <= 1'b0;
            shift_pat  <= eff_pat;
            shift_freq <= eff_freq;
            serial_out <= eff_pat[0];
            div_cnt    <= eff_freq[0] ? FAST_LOAD : SLOW_LOAD;
            bit_cnt    <= '0;
          end else begin
            state      <= CH_IDLE;
            busy       <= 1'b0;
            serial_out <= eff_idle;
          end
        end
        default: begin
          state <= CH_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/diff_freq_serial_out_mc.sv
// Packet assembler, inter-byte timeout and dispatch decode feeding CH_NUM independent
// serialiser engines.
module diff_freq_serial_out_mc
  import diff_freq_pkg::*;
#(
  parameter int DATA_BIT = 32,
  parameter int PACK_NUM = calc_pack_num(DATA_BIT),
  parameter int CH_NUM   = 4,
  parameter int FAST_DIV = 10,
  parameter int SLOW_DIV = 20,
  parameter int DIV_BIT  = 8,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_rx_done_tick,
  output logic [CH_NUM-1:0] o_serial_out,
  output logic [CH_NUM-1:0] o_bit_tick,
  output logic [CH_NUM-1:0] o_done_tick,
  output logic [CH_NUM-1:0] o_busy,
  output logic              o_pack_err
);

  localparam int               NB        = DATA_BIT / 8;
  localparam int               CNT_W     = $clog2(PACK_NUM);
  localparam int               TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PACK_NUM - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  logic [CNT_W-1:0]    byte_cnt;
  logic [TO_W-1:0]     idle_cnt;
  logic [DATA_BIT-1:0] pat_buf;
  logic [DATA_BIT-1:0] freq_buf;
  logic                timeout;
  logic                ctrl_strobe;
  logic                ch_ok;
  logic [CNT_W-1:0]    slot;

  logic [CH_NUM-1:0]   disp_sel;
  mode_e               disp_mode;
  logic                disp_idle;
  logic [DATA_BIT-1:0] disp_pattern;
  logic [DATA_BIT-1:0] disp_freq;
  logic                pack_err;

  // A byte arriving in the timeout cycle starts a fresh packet rather than extending the old one.
  always_comb begin
    timeout     = (byte_cnt != '0) && (idle_cnt == TO_LAST);
    slot        = timeout ? '0 : byte_cnt;
    ctrl_strobe = i_rx_done_tick && (slot == LAST_BYTE);
    ch_ok       = int'(i_data[CTRL_CH_LSB +: CTRL_CH_W]) < CH_NUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      idle_cnt <= '0;
      pat_buf  <= '0;
      freq_buf <= '0;
    end else begin
      if (i_rx_done_tick) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_LAST) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (i_rx_done_tick) begin
        byte_cnt <= (slot == LAST_BYTE) ? '0 : slot + 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (slot == CNT_W'(b)) begin
            pat_buf[b*8 +: 8] <= i_data;
          end
          if (slot == CNT_W'(NB + b)) begin
            freq_buf[b*8 +: 8] <= i_data;
          end
        end
      end else if (timeout) begin
        byte_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_sel     <= '0;
      disp_mode    <= MODE_NOP;
      disp_idle    <= 1'b0;
      disp_pattern <= '0;
      disp_freq    <= '0;
      pack_err     <= 1'b0;
    end else begin
      disp_sel <= '0;
      pack_err <= timeout;
      if (ctrl_strobe) begin
        for (int c = 0; c < CH_NUM; c++) begin
          disp_sel[c] <= ch_ok && (i_data[CTRL_CH_LSB +: CTRL_CH_W] == CTRL_CH_W'(c));
        end
        disp_mode    <= mode_e'(i_data[CTRL_MODE_LSB +: CTRL_MODE_W]);
        disp_idle    <= i_data[CTRL_IDLE_BIT];
        disp_pattern <= pat_buf;
        disp_freq    <= freq_buf;
        if (!ch_ok) begin
          pack_err <= 1'b1;
        end
      end
    end
  end

  assign o_pack_err = pack_err;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    dfso_channel #(
      .DATA_BIT(DATA_BIT),
      .FAST_DIV(FAST_DIV),
      .SLOW_DIV(SLOW_DIV),
      .DIV_BIT (DIV_BIT)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .disp_en     (disp_sel[c]),
      .disp_mode   (disp_mode),
      .disp_idle   (disp_idle),
      .disp_pattern(disp_pattern),
      .disp_freq   (disp_freq),
      .serial_out  (o_serial_out[c]),
      .bit_tick    (o_bit_tick[c]),
      .done_tick   (o_done_tick[c]),
      .busy        (o_busy[c])
    );
  end

endmodule

// File: tb/tb_diff_freq_serial_out_mc.sv
// Bench for diff_freq_serial_out_mc: directed and random packets checked every cycle
// against a waveform-level reference model of each channel.
module tb_diff_freq_serial_out_mc;

  localparam int DATA_BIT = 32;
  localparam int CH_NUM   = 4;
  localparam int FAST_DIV = 10;
  localparam int SLOW_DIV = 20;
  localparam int DIV_BIT  = 8;
  localparam int TIMEOUT  = 200;
  localparam int NB       = DATA_BIT / 8;
  localparam int PACK_NUM = NB * 2 + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        i_data;
  logic              i_rx_done_tick;
  logic [CH_NUM-1:0] o_serial_out;
  logic [CH_NUM-1:0] o_bit_tick;
  logic [CH_NUM-1:0] o_done_tick;
  logic [CH_NUM-1:0] o_busy;
  logic              o_pack_err;

  always #5 clk = ~clk;

  diff_freq_serial_out_mc #(
    .DATA_BIT(DATA_BIT),
    .CH_NUM  (CH_NUM),
    .FAST_DIV(FAST_DIV),
    .SLOW_DIV(SLOW_DIV),
    .DIV_BIT (DIV_BIT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_data        (i_data),
    .i_rx_done_tick(i_rx_done_tick),
    .o_serial_out  (o_serial_out),
    .o_bit_tick    (o_bit_tick),
    .o_done_tick   (o_done_tick),
    .o_busy        (o_busy),
    .o_pack_err    (o_pack_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt [CH_NUM];

  // Reference model: each running channel is described by its pass contents and the
  // number of cycles elapsed in that pass; outputs follow from summing bit periods.
  bit                  m_run  [CH_NUM];
  bit                  m_rep  [CH_NUM];
  bit                  m_pend [CH_NUM];
  bit                  m_idle [CH_NUM];
  int                  m_el   [CH_NUM];
  logic [DATA_BIT-1:0] m_pat  [CH_NUM];
  logic [DATA_BIT-1:0] m_freq [CH_NUM];
  logic [DATA_BIT-1:0] m_cpat [CH_NUM];
  logic [DATA_BIT-1:0] m_cfreq[CH_NUM];
  logic [7:0]          m_bytes[PACK_NUM];
  int                  m_nbytes;
  int                  m_gap;
  bit                  m_exp_err;
  bit                  dq_valid;
  int                  dq_ch;
  int                  dq_mode;
  bit                  dq_idle;
  logic [DATA_BIT-1:0] dq_pat;
  logic [DATA_BIT-1:0] dq_freq;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  function automatic int bit_period(input logic f);
    return f ? FAST_DIV : SLOW_DIV;
  endfunction

  function automatic int pass_len(input logic [DATA_BIT-1:0] freq);
    int sum = 0;
    for (int i = 0; i < DATA_BIT; i++) sum += bit_period(freq[i]);
    return sum;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH_NUM; c++) begin
      m_run[c] = 0; m_rep[c] = 0; m_pend[c] = 0; m_idle[c] = 0; m_el[c] = 0;
      m_pat[c] = '0; m_freq[c] = '0; m_cpat[c] = '0; m_cfreq[c] = '0;
    end
    m_nbytes = 0; m_gap = 0; m_exp_err = 0; dq_valid = 0;
    dq_ch = 0; dq_mode = 0; dq_idle = 0; dq_pat = '0; dq_freq = '0;
  endtask

  task automatic model_channel(input int c);
    bit was_run = m_run[c];
    if (was_run) m_el[c]++;
    if (dq_valid && dq_ch == c) begin
      m_pat[c] = dq_pat; m_freq[c] = dq_freq; m_idle[c] = dq_idle;
      if (dq_mode == 3) begin
        m_run[c] = 0; m_pend[c] = 0;
      end else if (dq_mode != 0) begin
        m_rep[c] = (dq_mode == 2);
        if (!was_run) begin
          m_run[c] = 1; m_el[c] = 0; m_pend[c] = 0;
          m_cpat[c] = dq_pat; m_cfreq[c] = dq_freq;
        end else begin
          m_pend[c] = 1;
        end
      end
    end
    if (was_run && m_run[c] && m_el[c] == pass_len(m_cfreq[c])) begin
      if (m_rep[c] || m_pend[c]) begin
        m_pend[c] = 0; m_el[c] = 0; m_cpat[c] = m_pat[c]; m_cfreq[c] = m_freq[c];
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  task automatic model_edge(input logic vld, input logic [7:0] data);
    int ch;
    for (int c = 0; c < CH_NUM; c++) model_channel(c);
    dq_valid  = 0;
    m_exp_err = 0;
    m_gap++;
    if (m_nbytes != 0 && m_gap == TIMEOUT) begin
      m_nbytes = 0; m_exp_err = 1;
    end
    if (vld) begin
      m_gap = 0;
      m_bytes[m_nbytes] = data;
      m_nbytes++;
      if (m_nbytes == PACK_NUM) begin
        m_nbytes = 0;
        dq_pat = '0; dq_freq = '0;
        for (int k = 0; k < NB; k++) begin
          dq_pat  = dq_pat  | (DATA_BIT'(m_bytes[k])      << (8 * k));
          dq_freq = dq_freq | (DATA_BIT'(m_bytes[NB + k]) << (8 * k));
        end
        ch = int'(data) / 16;
        if (ch >= CH_NUM) begin
          m_exp_err = 1;
        end else begin
          dq_valid = 1; dq_ch = ch; dq_mode = int'(data) % 4; dq_idle = data[2];
        end
      end
    end
  endtask

  task automatic check_cycle();
    logic [CH_NUM-1:0] es, eb, ed, ey;
    int acc;
    es = '0; eb = '0; ed = '0; ey = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (!m_run[c]) begin
        es[c] = m_idle[c];
      end else begin
        ey[c] = 1'b1;
        acc = 0;
        for (int i = 0; i < DATA_BIT; i++) begin
          if (m_el[c] >= acc && m_el[c] < acc + bit_period(m_cfreq[c][i])) begin
            es[c] = m_cpat[c][i];
            eb[c] = (m_el[c] == acc + bit_period(m_cfreq[c][i]) - 1);
            ed[c] = eb[c] && (i == DATA_BIT - 1);
          end
          acc += bit_period(m_cfreq[c][i]);
        end
      end
    end
    checkOutput("serial_out", 32'(o_serial_out), 32'(es));
    checkOutput("bit_tick",   32'(o_bit_tick),   32'(eb));
    checkOutput("done_tick",  32'(o_done_tick),  32'(ed));
    checkOutput("busy",       32'(o_busy),       32'(ey));
    checkOutput("pack_err",   32'(o_pack_err),   32'(m_exp_err));
  endtask

  task automatic applyStimulus(input logic vld, input logic [7:0] data);
    i_rx_done_tick = vld;
    i_data         = data;
    @(posedge clk);
    model_edge(vld, data);
    @(negedge clk);
    check_cycle();
    for (int c = 0; c < CH_NUM; c++) if (o_done_tick[c]) done_cnt[c]++;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic send_packet(input logic [DATA_BIT-1:0] pat, input logic [DATA_BIT-1:0] freq,
                             input logic [7:0] ctrl, input int gap);
    logic [7:0] b;
    for (int k = 0; k < PACK_NUM; k++) begin
      if (k < NB)          b = pat[k*8 +: 8];
      else if (k < 2 * NB) b = freq[(k-NB)*8 +: 8];
      else                 b = ctrl;
      applyStimulus(1'b1, b);
      if (k != PACK_NUM - 1) idle_cycles(gap);
    end
  endtask

  task automatic do_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_serial", 32'(o_serial_out), 32'd0);
    checkOutput("rst_busy",   32'(o_busy),       32'd0);
    checkOutput("rst_tick",   32'(o_bit_tick | o_done_tick), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] ctrl;
    int         ch;
    rst_n          = 1'b0;
    i_rx_done_tick = 1'b0;
    i_data         = 8'h00;
    foreach (done_cnt[c]) done_cnt[c] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("reset_serial",   32'(o_serial_out), 32'd0);
    checkOutput("reset_busy",     32'(o_busy),       32'd0);
    checkOutput("reset_pack_err", 32'(o_pack_err),   32'd0);
    rst_n = 1'b1;
    idle_cycles(3);

    $display("[TB] one-shot ch0");
    send_packet(32'h0000_00A5, 32'hFFFF_FFFF, 8'h01, 0);
    idle_cycles(340);
    checkOutput("ch0_done_count", 32'(done_cnt[0]), 32'd1);

    $display("[TB] mixed frequency ch2");
    send_packet(32'hFFFF_FFFF, 32'h0000_0001, 8'h25, 1);
    idle_cycles(650);
    checkOutput("ch2_idle_level", 32'(o_serial_out[2]), 32'd1);

    $display("[TB] repeat then update ch1");
    foreach (done_cnt[c]) done_cnt[c] = 0;
    send_packet(32'h0000_0001, 32'h0000_0000, 8'h12, 0);
    idle_cycles(100);
    send_packet(32'h0000_0002, 32'h0000_0000, 8'h11, 0);
    idle_cycles(1400);
    checkOutput("ch1_done_count", 32'(done_cnt[1]), 32'd2);
    checkOutput("ch1_busy_after", 32'(o_busy[1]),   32'd0);

    $display("[TB] stop ch3");
    foreach (done_cnt[c]) done_cnt[c] = 0;
    send_packet(DATA_BIT'($urandom), DATA_BIT'($urandom), 8'h32, 0);
    idle_cycles(150);
    send_packet(32'h0, 32'h0, 8'h33, 0);
    idle_cycles(3);
    checkOutput("ch3_busy_stop", 32'(o_busy[3]),   32'd0);
    checkOutput("ch3_no_done",   32'(done_cnt[3]), 32'd0);

    $display("[TB] bad channel index");
    send_packet(32'h1234_5678, 32'hFFFF_0000, 8'h51, 0);
    idle_cycles(5);
    send_packet(32'h0F0F_0F0F, 32'h0, 8'hF2, 2);
    idle_cycles(5);

    $display("[TB] inter-byte timeout");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'($urandom));
    idle_cycles(TIMEOUT + 5);
    send_packet(32'h0000_00C3, 32'hAAAA_AAAA, 8'h05, 0);
    idle_cycles(20);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'($urandom));
    idle_cycles(TIMEOUT - 1);
    send_packet(32'h0000_0F0F, 32'h5555_5555, 8'h21, 0);
    idle_cycles(700);

    $display("[TB] random packets");
    for (int p = 0; p < 16; p++) begin
      ch = $urandom_range(0, 5);
      if (ch >= CH_NUM) ch = $urandom_range(CH_NUM, 15);
      ctrl = {4'(ch), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3))};
      send_packet(DATA_BIT'($urandom), DATA_BIT'($urandom), ctrl, $urandom_range(0, 2));
      idle_cycles($urandom_range(0, 350));
    end

    $display("[TB] asynchronous reset mid-run");
    send_packet(DATA_BIT'($urandom), 32'hFFFF_FFFF, 8'h02, 0);
    idle_cycles(57);
    do_async_reset();
    send_packet(32'h0000_0005, 32'hFFFF_FFFF, 8'h31, 0);
    idle_cycles(340);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
